// File: rtl/sid_pkg.sv
// Shared audio types for the SID audio output path.
// Holds the stereo sample and gain types, the soft-mute state enum and the
// unity gain constant used by audio_soft_mute.
package sid;

    localparam int SID_BITS      = 24;
    localparam int SID_GAIN_BITS = 16;

    // Stereo sample, packed {left, right}, signed two's complement.
    typedef struct packed {
        logic signed [SID_BITS-1:0] left;
        logic signed [SID_BITS-1:0] right;
    } audio_t;

    // Unsigned gain, 0 .. 2^SID_GAIN_BITS inclusive.
    typedef logic [SID_GAIN_BITS:0] gain_t;

    localparam gain_t GAIN_UNITY = {1'b1, {SID_GAIN_BITS{1'b0}}};

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        UNITY     = 2'd2,
        RAMP_DOWN = 2'd3
    } mute_state_t;

endpackage

// File: rtl/audio_soft_mute_mul.sv
// audio_gain_mul: one audio channel times an unsigned fractional gain.
// Stage 1 registers the full signed product, stage 2 registers the product
// shifted back down by GAIN_BITS (arithmetic shift, i.e. floor) and truncated
// to the sample width. Shaped so the multiply maps onto a DSP/MAC block.
module audio_gain_mul #(
    parameter int BITS      = 24,
    parameter int GAIN_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_en,
    input  logic                   out_en,
    input  logic signed [BITS-1:0] sample,
    input  logic [GAIN_BITS:0]     gain,
    output logic signed [BITS-1:0] result
);

    localparam int PW = BITS + GAIN_BITS + 2;

    logic signed [PW-1:0] sample_ext;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] prod_q;

    // Gain is unsigned: a zero MSB keeps it positive in the signed multiply.
    assign sample_ext = PW'(sample);
    assign gain_ext   = PW'($signed({1'b0, gain}));

    // Stage 1: capture the product when a frame is accepted.
    // NOTE: the product register has no reset on purpose; the valid pipeline in
    // the parent is reset, so a stale product can never reach the output.
    always_ff @(posedge clk) begin
        if (in_en) begin
            prod_q <= sample_ext * gain_ext;
        end
    end

    // Stage 2: rescale and publish the sample.
    // NOTE: sequential state is always assigned with <= so every register
    // samples its inputs from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (out_en) begin
            result <= BITS'(prod_q >>> GAIN_BITS);
        end
    end

endmodule

// File: rtl/audio_soft_mute.sv
// audio_soft_mute: click-free gain ramp between the SID audio output and the
// I2S serializer. Ramps up from silence after reset, ramps down to silence on
// mute_req, updating the gain once per frame strobe.
// Optional build macro AUDIO_SOFT_MUTE_ZC_EN: defers leaving MUTED/UNITY until
// a left-channel zero crossing, forced after 256 frames of waiting.
module audio_soft_mute
    import sid::*;
#(
    parameter int BITS      = SID_BITS,
    parameter int GAIN_BITS = SID_GAIN_BITS,
    parameter int STEP      = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_stb,
    input  logic [2*BITS-1:0]   audio_i,
    input  logic                mute_req,
    output logic [2*BITS-1:0]   audio_o,
    output logic                out_stb,
    output logic                muted,
    output logic                unity
);

    localparam logic [GAIN_BITS:0]   UNITY_GAIN = {1'b1, {GAIN_BITS{1'b0}}};
    localparam logic [GAIN_BITS+1:0] STEP_EXT   = (GAIN_BITS+2)'(STEP);

    mute_state_t            state_q, state_d;
    logic [GAIN_BITS:0]     gain_q, gain_d;
    logic [GAIN_BITS+1:0]   up_sum;
    logic [GAIN_BITS:0]     up_gain;
    logic [GAIN_BITS:0]     down_gain;
    logic                   release_ok;
    logic                   stage1_vld_q;
    logic signed [BITS-1:0] left_o;
    logic signed [BITS-1:0] right_o;

    // Saturating ramp steps: clamp at unity and at zero, never wrap.
    assign up_sum    = {1'b0, gain_q} + STEP_EXT;
    assign up_gain   = (up_sum >= {1'b0, UNITY_GAIN}) ? UNITY_GAIN : up_sum[GAIN_BITS:0];
    assign down_gain = ({1'b0, gain_q} <= STEP_EXT) ? '0 : gain_q - STEP_EXT[GAIN_BITS:0];

`ifdef AUDIO_SOFT_MUTE_ZC_EN
    logic       prev_sign_q;
    logic [7:0] wait_q;
    logic       zero_cross;
    logic       gate_pending;

    assign zero_cross   = (audio_i[2*BITS-1:BITS] == '0) || (audio_i[2*BITS-1] != prev_sign_q);
    assign release_ok   = zero_cross || (wait_q == 8'hFF);
    assign gate_pending = ((state_q == MUTED) && !mute_req) || ((state_q == UNITY) && mute_req);

    // Track the left sign per frame and count frames spent waiting for a crossing.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sign_q <= 1'b0;
            wait_q      <= '0;
        end else if (sample_stb) begin
            prev_sign_q <= audio_i[2*BITS-1];
            if (gate_pending) begin
                wait_q <= release_ok ? 8'd0 : wait_q + 8'd1;
            end
        end
    end
`else
    assign release_ok = 1'b1;
`endif

    // Ramp state and gain register; the frame in flight already captured the old gain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUTED;
            gain_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    // Next-state and next-gain, evaluated only on a frame strobe.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        if (sample_stb) begin
            unique case (state_q)
                MUTED: begin
                    if (!mute_req && release_ok) begin
                        state_d = RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (mute_req) begin
                        state_d = RAMP_DOWN;
                    end else begin
                        gain_d = up_gain;
                        if (up_gain == UNITY_GAIN) begin
                            state_d = UNITY;
                        end
                    end
                end
                UNITY: begin
                    if (mute_req && release_ok) begin
                        state_d = RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (!mute_req) begin
                        state_d = RAMP_UP;
                    end else begin
                        gain_d = down_gain;
                        if (down_gain == '0) begin
                            state_d = MUTED;
                        end
                    end
                end
                default: begin
                    state_d = MUTED;
                    gain_d  = '0;
                end
            endcase
        end
    end

    // Frame valid pipeline, aligned with the two multiplier stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_vld_q <= 1'b0;
            out_stb      <= 1'b0;
        end else begin
            stage1_vld_q <= sample_stb;
            out_stb      <= stage1_vld_q;
        end
    end

    audio_gain_mul #(
        .BITS      (BITS),
        .GAIN_BITS (GAIN_BITS)
    ) u_mul_left (
        .clk    (clk),
        .rst    (rst),
        .in_en  (sample_stb),
        .out_en (stage1_vld_q),
        .sample (audio_i[2*BITS-1:BITS]),
        .gain   (gain_q),
        .result (left_o)
    );

    audio_gain_mul #(
        .BITS      (BITS),
        .GAIN_BITS (GAIN_BITS)
    ) u_mul_right (
        .clk    (clk),
        .rst    (rst),
        .in_en  (sample_stb),
        .out_en (stage1_vld_q),
        .sample (audio_i[BITS-1:0]),
        .gain   (gain_q),
        .result (right_o)
    );

    assign audio_o = {left_o, right_o};
    assign muted   = (state_q == MUTED);
    assign unity   = (state_q == UNITY);

endmodule

// File: tb/tb_audio_soft_mute.sv
// Testbench for audio_soft_mute. Two instances share the stimulus: the default
// STEP=64 and STEP=3000 (does not divide 65536, exercises clamping). A frame
// level model predicts every output each cycle; literal pins anchor the model.
module tb_audio_soft_mute;

    localparam int SILENT  = 0;
    localparam int RISING  = 1;
    localparam int FULL    = 2;
    localparam int FALLING = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic [47:0] ain;
    logic        mreq;

    logic [47:0] d_audio [2];
    logic        d_stb   [2];
    logic        d_muted [2];
    logic        d_unity [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    audio_soft_mute #(.BITS(24), .GAIN_BITS(16), .STEP(64)) dut (
        .clk(clk), .rst(rst), .sample_stb(stb), .audio_i(ain), .mute_req(mreq),
        .audio_o(d_audio[0]), .out_stb(d_stb[0]), .muted(d_muted[0]), .unity(d_unity[0])
    );

    audio_soft_mute #(.BITS(24), .GAIN_BITS(16), .STEP(3000)) dut_s (
        .clk(clk), .rst(rst), .sample_stb(stb), .audio_i(ain), .mute_req(mreq),
        .audio_o(d_audio[1]), .out_stb(d_stb[1]), .muted(d_muted[1]), .unity(d_unity[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_step [2] = '{64, 3000};
    int          m_gain [2];
    int          m_mode [2];
    int          m_wait [2];
    bit          m_prev;
    bit          m_v1   [2];
    logic [47:0] m_d1   [2];
    bit          e_stb  [2];
    logic [47:0] e_audio[2];
    bit          cmp_en = 1'b0;

    function automatic logic [47:0] scale(input logic [47:0] a, input int g);
        longint l, r;
        l = longint'($signed(a[47:24]));
        r = longint'($signed(a[23:0]));
        l = (l * g) >>> 16;
        r = (r * g) >>> 16;
        return {l[23:0], r[23:0]};
    endfunction

    function automatic void advance(input int i);
        bit go;
        int g;
        go = 1'b1;
`ifdef AUDIO_SOFT_MUTE_ZC_EN
        if ((m_mode[i] == SILENT && !mreq) || (m_mode[i] == FULL && mreq)) begin
            if (ain[47:24] == 24'd0 || ain[47] != m_prev || m_wait[i] == 255) begin
                m_wait[i] = 0;
            end else begin
                go = 1'b0;
                m_wait[i]++;
            end
        end
`endif
        case (m_mode[i])
            SILENT:  if (!mreq && go) m_mode[i] = RISING;
            RISING: begin
                if (mreq) m_mode[i] = FALLING;
                else begin
                    g = m_gain[i] + m_step[i];
                    if (g >= 65536) begin g = 65536; m_mode[i] = FULL; end
                    m_gain[i] = g;
                end
            end
            FULL:    if (mreq && go) m_mode[i] = FALLING;
            default: begin
                if (!mreq) m_mode[i] = RISING;
                else begin
                    g = m_gain[i] - m_step[i];
                    if (g <= 0) begin g = 0; m_mode[i] = SILENT; end
                    m_gain[i] = g;
                end
            end
        endcase
    endfunction

    // Model: a frame accepted at edge E appears at the outputs after edge E+1.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_gain[i] = 0; m_mode[i] = SILENT; m_wait[i] = 0;
                m_v1[i] = 1'b0; e_stb[i] = 1'b0; e_audio[i] = '0;
            end else begin
                e_stb[i] = m_v1[i];
                if (m_v1[i]) e_audio[i] = m_d1[i];
                m_v1[i] = stb;
                if (stb) begin
                    m_d1[i] = scale(ain, m_gain[i]);
                    advance(i);
                end
            end
        end
        if (rst) m_prev = 1'b0;
        else if (stb) m_prev = ain[47];
        if (rst) cmp_en = 1'b1;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("cyc_stb%0d", i),   64'(d_stb[i]),   64'(e_stb[i]));
                check($sformatf("cyc_audio%0d", i), 64'(d_audio[i]), 64'(e_audio[i]));
                check($sformatf("cyc_muted%0d", i), 64'(d_muted[i]), 64'(m_mode[i] == SILENT));
                check($sformatf("cyc_unity%0d", i), 64'(d_unity[i]), 64'(m_mode[i] == FULL));
            end
        end
    end

    // ---------------- stimulus ----------------
    // One frame: strobe for one cycle, return once its output is visible.
    task automatic frame();
        @(posedge clk); #1 stb = 1'b1;
        @(posedge clk); #1 stb = 1'b0;
        @(posedge clk); #1;
    endtask

    // One frame whose left sample is zero (a zero crossing in either build).
    task automatic zero_frame();
        logic [47:0] keep;
        keep = ain;
        ain  = {24'd0, keep[23:0]};
        frame();
        ain  = keep;
    endtask

    logic [47:0] bv [6] = '{48'h123456_FEDCBA, 48'h000000_000000, 48'h7FFFFF_800000,
                            48'hFFFFFF_000001, 48'h800000_7FFFFF, 48'h3A5C00_C5A400};
    int n;
    int cur, prv;

    initial begin
        rst = 1'b1; stb = 1'b0; ain = '0; mreq = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_muted",  64'(d_muted[0]), 64'd1);
        check("rst_unity",  64'(d_unity[0]), 64'd0);
        check("rst_audio",  64'(d_audio[0]), 64'd0);
        check("rst_stb",    64'(d_stb[0]),   64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: ramp up from silence
        ain = {24'h400000, 24'hC00000};
        zero_frame();
        check("t1_f1_audio", 64'(d_audio[0]), 64'd0);
        check("t1_f1_muted", 64'(d_muted[0]), 64'd0);
        frame();
        check("t1_f2_audio", 64'(d_audio[0]), 64'd0);
        frame();
        check("t1_f3_audio", 64'(d_audio[0]), 64'h001000_FFF000);
        n = 0;
        while (m_mode[0] != FULL && n < 2000) begin frame(); n++; end
        check("t1_frames_to_unity", 64'(n), 64'd1022);
        check("t1_model_gain0", 64'(m_gain[0]), 64'd65536);
        check("t1_model_gain1", 64'(m_gain[1]), 64'd65536);
        check("t1_unity", 64'(d_unity[0]), 64'd1);
        frame();
        check("t1_exact0", 64'(d_audio[0]), 64'h400000_C00000);
        check("t1_exact1", 64'(d_audio[1]), 64'h400000_C00000);

        // 4: full scale at unity, then a back-to-back burst
        ain = {24'h7FFFFF, 24'h800000};
        frame();
        check("t4_fullscale0", 64'(d_audio[0]), 64'h7FFFFF_800000);
        check("t4_fullscale1", 64'(d_audio[1]), 64'h7FFFFF_800000);
        @(posedge clk); #1 stb = 1'b1; ain = bv[0];
        for (int k = 1; k < 6; k++) begin @(posedge clk); #1 ain = bv[k]; end
        @(posedge clk); #1 stb = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("t4_burst_last", 64'(d_audio[0]), 64'h3A5C00_C5A400);

        // 2: ramp down to silence
        ain = {24'h400000, 24'hC00000};
        mreq = 1'b1;
        zero_frame();
        prv = 32'h400000;
        n = 0;
        while (m_mode[0] != SILENT && n < 2000) begin
            frame(); n++;
            cur = int'($signed(d_audio[0][47:24]));
            check("t2_monotonic", 64'(cur <= prv), 64'd1);
            prv = cur;
        end
        check("t2_frames_to_mute", 64'(n), 64'd1024);
        check("t2_model_gain1", 64'(m_gain[1]), 64'd0);
        frame();
        check("t2_audio_zero", 64'(d_audio[0]), 64'd0);
        check("t2_muted0", 64'(d_muted[0]), 64'd1);
        check("t2_muted1", 64'(d_muted[1]), 64'd1);

        // 3: reversal at half gain, then back up at quarter gain
        mreq = 1'b0;
        zero_frame();
        n = 0;
        while (m_gain[0] != 32768 && n < 2000) begin frame(); n++; end
        check("t3_frames_to_half", 64'(n), 64'd512);
        mreq = 1'b1;
        frame(); check("t3_rev_a", 64'(d_audio[0][47:24]), 64'h200000);
        frame(); check("t3_rev_b", 64'(d_audio[0][47:24]), 64'h200000);
        frame(); check("t3_rev_c", 64'(d_audio[0][47:24]), 64'h1FF000);
        n = 0;
        while (m_gain[0] != 16384 && n < 2000) begin frame(); n++; end
        mreq = 1'b0;
        frame(); check("t3_up_a", 64'(d_audio[0][47:24]), 64'h100000);
        frame(); check("t3_up_b", 64'(d_audio[0][47:24]), 64'h100000);
        frame(); check("t3_up_c", 64'(d_audio[0][47:24]), 64'h101000);

        // 5: reset mid-ramp with a frame in flight
        @(posedge clk); #1 stb = 1'b1;
        @(posedge clk); #1 stb = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_no_stb", 64'(d_stb[0]), 64'd0);
        end
        check("t5_audio", 64'(d_audio[0]), 64'd0);
        check("t5_muted", 64'(d_muted[0]), 64'd1);
        zero_frame();
        check("t5_f1", 64'(d_audio[0]), 64'd0);
        frame();
        check("t5_f2", 64'(d_audio[0]), 64'd0);
        frame();
        check("t5_f3", 64'(d_audio[0][47:24]), 64'h001000);

`ifdef AUDIO_SOFT_MUTE_ZC_EN
        // 6: zero-crossing gating and its timeout
        n = 0;
        while (m_mode[0] != FULL && n < 2000) begin frame(); n++; end
        mreq = 1'b1;
        repeat (255) frame();
        check("t6_still_unity", 64'(d_unity[0]), 64'd1);
        frame();
        check("t6_timeout_leave", 64'(d_unity[0]), 64'd0);
        frame();
        check("t6_f257", 64'(d_audio[0][47:24]), 64'h400000);
        frame();
        check("t6_f258", 64'(d_audio[0][47:24]), 64'h3FF000);
        n = 0;
        while (m_mode[0] != SILENT && n < 2000) begin frame(); n++; end
        mreq = 1'b0;
        frame();
        check("t6_no_cross", 64'(d_muted[0]), 64'd1);
        ain = {24'hC00000, 24'h400000};
        frame();
        check("t6_cross", 64'(d_muted[0]), 64'd0);
`endif

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_soft_mute.md
Name: audio_soft_mute

Overview:
- Click-free gain ramp stage between the SID API audio output and the I2S DSP-mode serializer.
- Ramps stereo audio from silence to unity gain after reset, so the codec never sees a step from garbage or DC.
- Ramps back down to silence on a mute request, e.g. before a warmboot into the bootloader.
- Gain is updated once per audio frame, using the frame strobe supplied by the I2S side.

Parameters:
- BITS, 24: signed sample width per channel.
- GAIN_BITS, 16: fractional gain bits; unity gain = 2^GAIN_BITS.
- STEP, 64: gain increment/decrement per frame; default gives a 1024-frame ramp.

Ports:
- clk  in  1  system audio clock (clk_24 domain).
- rst  in  1  synchronous, active-high reset.
- sample_stb  in  1  one-cycle pulse per audio frame; marks audio_i valid and requests a new output.
- audio_i  in  2*BITS  packed {left, right}, signed two's complement.
- mute_req  in  1  level; 1 = ramp to silence and hold, 0 = ramp to unity.
- audio_o  out  2*BITS  packed {left, right}, gain-scaled.
- out_stb  out  1  one-cycle pulse when audio_o updates.
- muted  out  1  state MUTED.
- unity  out  1  state UNITY.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=MUTED, gain=0, audio_o=0, out_stb=0, muted=1, unity=0. Pipeline valids are cleared; a strobe in flight is discarded.
- Gain register: unsigned, GAIN_BITS+1 wide, range 0..2^GAIN_BITS.
- Pipeline, 2 stages:
  - Cycle N (sample_stb=1): capture audio_i and the current gain. Compute per-channel product = sample * {1'b0, gain}, signed, BITS+GAIN_BITS+2 wide.
  - Cycle N+1: audio_o = product >>> GAIN_BITS (arithmetic, floor), truncated to BITS. out_stb=1 at N+2 as seen by the consumer, i.e. audio_o and out_stb are registered together.
  - No saturation is needed because gain <= unity. Unity must pass samples bit-exact. Gain 0 must output exactly 0.
- Gain and state update on every sample_stb, after the gain value is captured. The frame uses the old gain; the new gain applies from the next frame.
- State transitions (evaluated only when sample_stb=1):
  - MUTED:
    - mute_req=0 -> RAMP_UP.
    - Otherwise hold gain=0.
  - RAMP_UP:
    - mute_req=1 -> RAMP_DOWN; gain unchanged this frame.
    - Else gain = min(gain+STEP, 2^GAIN_BITS).
    - Reaching 2^GAIN_BITS -> UNITY.
  - UNITY:
    - mute_req=1 -> RAMP_DOWN.
    - Otherwise hold.
  - RAMP_DOWN:
    - mute_req=0 -> RAMP_UP; gain unchanged this frame.
    - Else gain = max(gain-STEP, 0).
    - Reaching 0 -> MUTED.
- mute_req toggles between strobes: only the level sampled at the strobe matters.
- STEP not dividing 2^GAIN_BITS: clamping at both ends is mandatory. No wrap-around.
- sample_stb on consecutive cycles: each is accepted, and the pipeline must sustain one frame per cycle.
- rst mid-ramp: immediately MUTED, gain 0. The next ramp restarts from 0.

Optional Feature:
- Macro: AUDIO_SOFT_MUTE_ZC_EN.
- Defined:
  - Transitions out of MUTED and UNITY are deferred until a zero crossing: the sign of the left input differs from the previous frame's left sign, or the left input is 0.
  - Timeout: the transition is forced after 256 frames of waiting. An 8-bit wait counter is cleared on transition.
  - Ramp reversals (RAMP_UP <-> RAMP_DOWN) are not gated.
- Undefined: transitions occur on the first qualifying strobe, as above.

Decomposition:
- Shared package sid holds:
  - audio_t ({left, right} signed BITS).
  - gain_t.
  - enum mute_state_t {MUTED, RAMP_UP, UNITY, RAMP_DOWN}.
  - Constant GAIN_UNITY.
- Sub-module audio_gain_mul: a single-channel registered signed × unsigned multiply and shift. It is instantiated twice (left/right) and maps to iCE40 DSP/MAC inference.

Test Plan:
1. Reset, mute_req=0, audio_i={24'sh400000, -24'sh400000}, strobe every 500 cycles:
   - out_stb on strobes 1–2 gives audio_o=0.
   - muted drops after strobe 1.
   - Gain reaches 65536 after 1024 strobes; unity=1.
   - Afterwards audio_o == audio_i bit-exact.
2. In UNITY, assert mute_req:
   - Output magnitude decreases monotonically by ~STEP/65536 per frame.
   - After 1024 strobes muted=1 and audio_o=0.
3. Reversal: mute_req=1 at gain=32768:
   - Next frame gain is still 32768, then it decreases.
   - Deassert mute_req at 16384: the ramp resumes upward with no step.
4. Boundary STEP=3000:
   - Gain clamps to exactly 65536 (no overflow) and exactly 0 on the way down.
   - Full-scale inputs 24'sh7FFFFF / 24'sh800000 at unity are unchanged.
5. Assert rst for one cycle mid-ramp with a strobe in flight:
   - No out_stb emitted.
   - audio_o=0, muted=1.
   - The next ramp starts from gain 0.
6. (AUDIO_SOFT_MUTE_ZC_EN) Constant positive input in UNITY with mute_req=1:
   - Ramp starts at strobe 257 (timeout).
   - With a sign-alternating input, the ramp starts on the first crossing.
